// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the keypad scanner.
package kbd_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int KEY_W     = 4;
    localparam int REP_FIRST = 128;
    localparam int REP_NEXT  = 32;
endpackage

// File: rtl/kbd_scan_sync2.sv
// sync2: 2-FF synchronizer with async active-low reset and configurable reset value.
module sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_q, s2_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/kbd_scan.sv
// kbd_scan: 4x4 matrix keypad scanner with strobe-based debounce.
// Define KBD_REPEAT_EN to enable auto-repeat of key_valid while a key stays held.
module kbd_scan import kbd_pkg::*; #(
    parameter int TAP_BIT = 17,
    parameter int DEB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      div_bus,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);
    localparam logic [3:0] DEB = 4'(DEB_CNT);

    logic [COLS-1:0]  col_s;
    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d, col_q, col_d, col;
    logic [3:0]       cnt_q, cnt_d, rcnt_q, rcnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d, tap_q, tap_d;
    logic             strb, hit, accept, rep_fire, unused_div;

    // Idle columns read high, so the synchronizer resets to all-ones.
    sync2 #(.W(COLS), .RST_VAL('1)) u_sync (.clk(clk), .rst(rst), .d(col_n), .q(col_s));

    assign tap_d      = div_bus[TAP_BIT];
    assign strb       = tap_d & ~tap_q;
    assign unused_div = ^div_bus;
    assign hit        = ~&col_s;
    assign col        = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        accept  = 1'b0;
        if (strb) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        col_d   = col;
                        cnt_d   = 4'd1;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit && col == col_q) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    rcnt_d = hit ? 4'd0 : rcnt_q + 4'd1;
                    if (rcnt_d == DEB) begin
                        rcnt_d  = 4'd0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                default: state_d = SCAN;
            endcase
            // Covers both the DEB_CNT==1 shortcut from SCAN and the final debounce sample.
            if (state_d == DEBOUNCE && cnt_d == DEB) begin
                accept  = 1'b1;
                cnt_d   = 4'd0;
                rcnt_d  = 4'd0;
                state_d = HELD;
            end
        end
        valid_d = accept | rep_fire;
        code_d  = accept ? {row_q, col_d} : code_q;
    end

`ifdef KBD_REPEAT_EN
    logic [6:0] rep_q, rep_d;
    // After the first repeat the counter restarts at REP_FIRST-REP_NEXT so later repeats come every REP_NEXT strobes.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (strb && state_q == HELD) begin
            if (!hit) begin
                rep_d = 7'd0;
            end else if (rep_q == 7'(REP_FIRST - 1)) begin
                rep_fire = 1'b1;
                rep_d    = 7'(REP_FIRST - REP_NEXT);
            end else begin
                rep_d = rep_q + 7'd1;
            end
        end
        if (accept) rep_d = 7'd0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rep_q <= 7'd0;
        else      rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            cnt_q   <= 4'd0;
            rcnt_q  <= 4'd0;
            code_q  <= '0;
            valid_q <= 1'b0;
            tap_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            tap_q   <= tap_d;
        end
    end

    assign row_n     = ~(4'b0001 << row_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = state_q == HELD;
endmodule
